// File: rtl/clock_pattern_detector.sv
// clock_pattern_detector: forwarded-clock training detector for CKP/CKN/TRACK.
// Three oversampled lanes count rising edges per burst and flag a lane once it
// sees PASS_ITER consecutive bursts of exactly BURST_LEN edges. A small FSM on
// i_dig_clk runs detection, times out, and latches the per-lane result.
// Optional feature macro: CLK_DET_ERR_CNT_EN adds o_err_cnt (invalid-burst counts).
//
// state    | meaning
// S_IDLE   | waiting for a rising edge on i_start_detect
// S_DETECT | lanes enabled, waiting for all-pass or timeout
// S_DONE   | result held on o_pass until i_start_detect falls
module clock_pattern_detector #(
  parameter int OVS       = 4,
  parameter int BURST_LEN = 16,
  parameter int GAP_MIN   = 2 * OVS,
  parameter int PASS_ITER = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic        i_dig_clk,
  input  logic        i_rst_n,
  input  logic        i_sample_clk,
  input  logic        i_rx_ckp,
  input  logic        i_rx_ckn,
  input  logic        i_rx_track,
  input  logic        i_start_detect,
  input  logic        i_ltsm_in_reset,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_pass
`ifdef CLK_DET_ERR_CNT_EN
  ,
  output logic [23:0] o_err_cnt
`endif
);

  localparam int GW = $clog2(GAP_MIN + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_DETECT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      pass_q, pass_d;
  logic            start_q;
  logic [2:0]      pass_meta_q, pass_sync_q;
  logic [1:0]      en_q;
  logic            en_s;
  logic [2:0]      pass_s;
  logic [2:0]      rx_raw;

  assign rx_raw = {i_rx_track, i_rx_ckn, i_rx_ckp};
  assign en_s   = en_q[1];

`ifdef CLK_DET_ERR_CNT_EN
  logic [23:0] err_s;
  logic [23:0] err_meta_q, err_sync_q;
  logic [23:0] err_q, err_d;
`endif

  // DETECT enable into the sample domain; busy_q is a flop so it is glitch-free
  always_ff @(posedge i_sample_clk or negedge i_rst_n) begin
    if (!i_rst_n) en_q <= '0;
    else          en_q <= {en_q[0], busy_q};
  end

  for (genvar g = 0; g < 3; g++) begin : g_lane
    logic [2:0]    rx_q;
    logic [4:0]    edge_cnt_q, edge_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [6:0]    run_cnt_q, run_cnt_d;
    logic          lane_pass_q, lane_pass_d;
    logic          rise;
    logic          burst_end;
`ifdef CLK_DET_ERR_CNT_EN
    logic [7:0]    err_cnt_q, err_cnt_d;
`endif

    // rx_q[0] metastable stage, rx_q[1] synced, rx_q[2] previous for edge detect
    assign rise      = rx_q[1] & ~rx_q[2];
    assign burst_end = !rise && (gap_cnt_q == GW'(GAP_MIN - 1)) && (edge_cnt_q != 5'd0);

    // Burst accounting; everything clears while disabled so a partial burst is dropped
    always_comb begin
      edge_cnt_d  = edge_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      run_cnt_d   = run_cnt_q;
      lane_pass_d = lane_pass_q;
`ifdef CLK_DET_ERR_CNT_EN
      err_cnt_d   = err_cnt_q;
`endif
      if (!en_s) begin
        edge_cnt_d  = '0;
        gap_cnt_d   = '0;
        run_cnt_d   = '0;
        lane_pass_d = 1'b0;
`ifdef CLK_DET_ERR_CNT_EN
        err_cnt_d   = '0;
`endif
      end else begin
        if (rise) begin
          if (edge_cnt_q != 5'd31) edge_cnt_d = edge_cnt_q + 5'd1;
          gap_cnt_d = '0;
        end else if (gap_cnt_q != GW'(GAP_MIN)) begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
        if (burst_end) begin
          edge_cnt_d = '0;
          if (edge_cnt_q == 5'(BURST_LEN)) begin
            if (run_cnt_q != 7'h7f) run_cnt_d = run_cnt_q + 7'd1;
          end else begin
            run_cnt_d = '0;
`ifdef CLK_DET_ERR_CNT_EN
            if (err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
`endif
          end
        end
        if (run_cnt_q >= 7'(PASS_ITER)) lane_pass_d = 1'b1;
      end
    end

    // Lane registers in the oversampling domain
    always_ff @(posedge i_sample_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rx_q        <= '0;
        edge_cnt_q  <= '0;
        gap_cnt_q   <= '0;
        run_cnt_q   <= '0;
        lane_pass_q <= 1'b0;
`ifdef CLK_DET_ERR_CNT_EN
        err_cnt_q   <= '0;
`endif
      end else begin
        rx_q        <= {rx_q[1:0], rx_raw[g]};
        edge_cnt_q  <= edge_cnt_d;
        gap_cnt_q   <= gap_cnt_d;
        run_cnt_q   <= run_cnt_d;
        lane_pass_q <= lane_pass_d;
`ifdef CLK_DET_ERR_CNT_EN
        err_cnt_q   <= err_cnt_d;
`endif
      end
    end

    assign pass_s[g] = lane_pass_q;
`ifdef CLK_DET_ERR_CNT_EN
    assign err_s[8*g +: 8] = err_cnt_q;
`endif
  end

  // Pass flags (and error counts) into the control domain. Both are quasi-static:
  // counts only move at burst ends, tens of cycles apart, so the sampled word is settled.
  always_ff @(posedge i_dig_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pass_meta_q <= '0;
      pass_sync_q <= '0;
`ifdef CLK_DET_ERR_CNT_EN
      err_meta_q  <= '0;
      err_sync_q  <= '0;
`endif
    end else begin
      pass_meta_q <= pass_s;
      pass_sync_q <= pass_meta_q;
`ifdef CLK_DET_ERR_CNT_EN
      err_meta_q  <= err_s;
      err_sync_q  <= err_meta_q;
`endif
    end
  end

  // Next-state and registered-output logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef CLK_DET_ERR_CNT_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start_detect && !start_q) begin
          state_d = S_DETECT;
          tmr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_DETECT: begin
        if (pass_sync_q == 3'b111 || tmr_q == TW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = pass_sync_q;
`ifdef CLK_DET_ERR_CNT_EN
          err_d   = err_sync_q;
`endif
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DONE: begin
        if (!i_start_detect && start_q) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          pass_d  = '0;
`ifdef CLK_DET_ERR_CNT_EN
          err_d   = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (i_ltsm_in_reset) begin
      state_d = S_IDLE;
      tmr_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = '0;
`ifdef CLK_DET_ERR_CNT_EN
      err_d   = '0;
`endif
    end
  end

  // Control FSM state and outputs
  always_ff @(posedge i_dig_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= '0;
      start_q <= 1'b0;
`ifdef CLK_DET_ERR_CNT_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      start_q <= i_start_detect;
`ifdef CLK_DET_ERR_CNT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_pass = pass_q;
`ifdef CLK_DET_ERR_CNT_EN
  assign o_err_cnt = err_q;
`endif

endmodule

// File: tb/tb_clock_pattern_detector.sv
// Testbench for clock_pattern_detector: burst-level reference model, directed
// scenarios plus randomized burst corruption.
module tb_clock_pattern_detector;

  logic       dig_clk  = 1'b0;
  logic       smp_clk  = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx_ckp   = 1'b0;
  logic       rx_ckn   = 1'b0;
  logic       rx_track = 1'b0;
  logic       start    = 1'b0;
  logic       ltsm     = 1'b0;
  logic       busy;
  logic       done;
  logic [2:0] pass;
`ifdef CLK_DET_ERR_CNT_EN
  logic [23:0] err_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int lens [3][32];
  int nb   [3];

  always #5 dig_clk = ~dig_clk;
  always #1 smp_clk = ~smp_clk;

  clock_pattern_detector dut (
    .i_dig_clk       (dig_clk),
    .i_rst_n         (rst_n),
    .i_sample_clk    (smp_clk),
    .i_rx_ckp        (rx_ckp),
    .i_rx_ckn        (rx_ckn),
    .i_rx_track      (rx_track),
    .i_start_detect  (start),
    .i_ltsm_in_reset (ltsm),
    .o_busy          (busy),
    .o_done          (done),
    .o_pass          (pass)
`ifdef CLK_DET_ERR_CNT_EN
    ,
    .o_err_cnt       (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int l, input logic v);
    case (l)
      0:       rx_ckp   = v;
      1:       rx_ckn   = v;
      default: rx_track = v;
    endcase
  endtask

  // Forwarded clock: period 8 = 4 sample clocks, then 8 gated periods
  task automatic drive_lane(input int l);
    for (int b = 0; b < nb[l]; b++) begin
      for (int e = 0; e < lens[l][b]; e++) begin
        set_rx(l, 1'b1); #4;
        set_rx(l, 1'b0); #4;
      end
      #64;
    end
  endtask

  task automatic fill(input int l, input int n, input int len);
    nb[l] = n;
    for (int b = 0; b < 32; b++) lens[l][b] = (b < n) ? len : 0;
  endtask

  // A lane passes once it has seen 16 consecutive bursts of exactly 16 edges
  function automatic logic model_pass(input int l);
    int run = 0;
    logic p = 1'b0;
    for (int b = 0; b < nb[l]; b++) begin
      run = (lens[l][b] == 16) ? run + 1 : 0;
      if (run >= 16) p = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [7:0] model_err(input int l);
    int c = 0;
    for (int b = 0; b < nb[l]; b++) if (lens[l][b] != 16) c++;
    return (c > 255) ? 8'hff : 8'(c);
  endfunction

  task automatic run_case(input string tag);
    logic [2:0] exp;
    int cyc;
    int busy_cyc;
    logic got;
    exp = {model_pass(2), model_pass(1), model_pass(0)};
    cyc = 0; busy_cyc = 0; got = 1'b0;
    @(negedge dig_clk); start = 1'b1;
    fork
      begin
        repeat (3) @(negedge dig_clk);
        fork
          drive_lane(0);
          drive_lane(1);
          drive_lane(2);
        join
      end
      begin
        while (!got && cyc < 1500) begin
          @(posedge dig_clk); #1;
          cyc++;
          if (busy) busy_cyc++;
          if (done) got = 1'b1;
        end
      end
    join
    @(negedge dig_clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'(exp));
    if (exp == 3'b111) check({tag, "_early"}, 32'(busy_cyc < 1024), 32'd1);
    else               check({tag, "_timeout_len"}, 32'(busy_cyc), 32'd1024);
`ifdef CLK_DET_ERR_CNT_EN
    if (exp != 3'b111)
      check({tag, "_err"}, 32'(err_cnt), 32'({model_err(2), model_err(1), model_err(0)}));
`endif
    start = 1'b0;
    @(negedge dig_clk);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_pass"}, 32'(pass), 32'd0);
  endtask

  initial begin
    for (int l = 0; l < 3; l++) fill(l, 0, 16);
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    repeat (2) @(negedge dig_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge dig_clk);
    check("idle_no_start", 32'(busy), 32'd0);

    // 20 good bursts on all lanes
    for (int l = 0; l < 3; l++) fill(l, 20, 16);
    run_case("all_good");

    // CKN bursts one edge short
    for (int l = 0; l < 3; l++) fill(l, 24, 16);
    fill(1, 24, 15);
    run_case("ckn_short");

    // one long burst after 10 good ones, then 16 more good
    for (int l = 0; l < 3; l++) begin
      fill(l, 27, 16);
      lens[l][10] = 17;
    end
    run_case("long_burst");

    // randomized corruption per lane
    for (int it = 0; it < 4; it++) begin
      for (int l = 0; l < 3; l++) begin
        int mode;
        fill(l, 24, 16);
        mode = int'($urandom_range(0, 2));
        if (mode >= 1) lens[l][$urandom_range(0, 23)] = ($urandom_range(0, 1) != 0) ? 15 : 17;
        if (mode == 2) lens[l][$urandom_range(0, 23)] = ($urandom_range(0, 1) != 0) ? 14 : 18;
      end
      run_case($sformatf("rand%0d", it));
    end

    // abort mid-DETECT
    @(negedge dig_clk); start = 1'b1;
    repeat (50) @(negedge dig_clk);
    check("abort_pre_busy", 32'(busy), 32'd1);
    ltsm = 1'b1;
    @(posedge dig_clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    @(negedge dig_clk); ltsm = 1'b0;
    repeat (5) @(negedge dig_clk);
    check("abort_level_no_restart", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge dig_clk);
    start = 1'b1; ltsm = 1'b1;
    @(negedge dig_clk); ltsm = 1'b0;
    check("rise_with_abort", 32'(busy), 32'd0);
    repeat (3) @(negedge dig_clk);
    check("rise_with_abort_hold", 32'(busy), 32'd0);
    start = 1'b0;
    for (int l = 0; l < 3; l++) fill(l, 24, 16);
    run_case("restart");

    // async reset mid-burst
    @(negedge dig_clk); start = 1'b1;
    fork
      begin
        repeat (3) @(negedge dig_clk);
        fork
          drive_lane(0);
          drive_lane(1);
          drive_lane(2);
        join
      end
      begin
        repeat (60) @(negedge dig_clk);
        check("rst_mid_pre_busy", 32'(busy), 32'd1);
        #3; rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_pass", 32'(pass), 32'd0);
        start = 1'b0;
        repeat (5) @(negedge dig_clk);
        rst_n = 1'b1;
        repeat (20) @(negedge dig_clk);
        check("rst_mid_idle", 32'(busy), 32'd0);
        check("rst_mid_idle_done", 32'(done), 32'd0);
      end
    join

    // restart with no clock present
    for (int l = 0; l < 3; l++) fill(l, 0, 16);
    run_case("no_clock");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
